grb_bit_encoder: RTL and testbench

GRB_BIT_ENCODER -- requirements
Module: grb_bit_encoder

---
 rtl/grb_pkg.sv | 37 +++
 rtl/grb_scale.sv | 34 +++
 rtl/grb_bit_encoder.sv | 197 +++++++++++++++++++
 tb/tb_grb_bit_encoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grb_pkg.sv
// -----------------------------------------------------------------------------
// grb_pkg
// Shared definitions for the GRB serial LED bit encoder.
//   - grb_state_t : encoder FSM states (IDLE / HIGH / LOW / LATCH)
//   - *_DEF       : default waveform timing, in clk cycles (50 MHz clock)
//   - high_len()  : selects the high-phase length for one data bit
// -----------------------------------------------------------------------------
package grb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } grb_state_t;

    localparam int unsigned T0H_CYC_DEF   = 32'd20;
    localparam int unsigned T1H_CYC_DEF   = 32'd40;
    localparam int unsigned TBIT_CYC_DEF  = 32'd62;
    localparam int unsigned LATCH_CYC_DEF = 32'd2500;

    // High-phase length of a bit: long pulse for a 1, short pulse for a 0.
    function automatic logic [15:0] high_len(
        input logic        bit_val,
        input logic [15:0] t0h,
        input logic [15:0] t1h
    );
        logic [15:0] len;
        if (bit_val) begin
            len = t1h;
        end else begin
            len = t0h;
        end
        return len;
    endfunction

endpackage

// File: rtl/grb_scale.sv
// -----------------------------------------------------------------------------
// grb_scale
// Combinational brightness scaler. Each 8-bit channel c becomes
// (c * (bright + 1)) >> 8, so bright = 255 passes the pixel through unchanged
// and bright = 0 reduces every channel to 0.
// Ports:
//   pix_in  [23:0] : pixel {G,R,B} before scaling
//   bright  [7:0]  : global brightness
//   pix_out [23:0] : scaled pixel {G,R,B}
// -----------------------------------------------------------------------------
module grb_scale (
    input  logic [23:0] pix_in,
    input  logic [7:0]  bright,
    output logic [23:0] pix_out
);

    logic [8:0] bright_p1_s;

    // One 8x9 multiply per channel; the product always fits in 16 bits.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] k);
        logic [16:0] prod;
        prod = {9'd0, c} * {8'd0, k};
        return 8'(prod >> 8);
    endfunction

    // Channel scaling, G/R/B each through its own multiplier.
    always_comb begin
        bright_p1_s = {1'b0, bright} + 9'd1;
        pix_out     = {scale_ch(pix_in[23:16], bright_p1_s),
                       scale_ch(pix_in[15:8],  bright_p1_s),
                       scale_ch(pix_in[7:0],   bright_p1_s)};
    end

endmodule

// File: rtl/grb_bit_encoder.sv
// -----------------------------------------------------------------------------
// grb_bit_encoder
// Serialises 24-bit GRB pixels onto a single-wire LED strip line. Each bit is
// TBIT_CYC cycles: high for T1H_CYC (bit 1) or T0H_CYC (bit 0), low for the
// rest. After the last pixel of a frame the line is held low for LATCH_CYC
// cycles so the strip latches.
// Optional feature macro: GRB_BRIGHTNESS_EN adds input bright[7:0] and scales
// every channel through grb_scale before loading.
// Ports:
//   clk           : clock
//   reset         : asynchronous active-high reset
//   pix_data[23:0]: pixel {G,R,B}, MSB (G7) transmitted first
//   pix_valid     : pix_data valid
//   pix_last      : final pixel of frame (qualified by pix_valid)
//   bright[7:0]   : brightness (GRB_BRIGHTNESS_EN only)
//   pix_ready     : encoder accepts a pixel this cycle
//   dout          : serial line to the strip
//   inc_counter   : one-cycle pulse per completed bit
//   clear_counter : one-cycle pulse at the end of the latch period
//   busy          : encoder not idle
//   underrun      : sticky, frame ran dry before a pix_last pixel
// -----------------------------------------------------------------------------
module grb_bit_encoder
    import grb_pkg::*;
#(
    parameter int unsigned T0H_CYC   = T0H_CYC_DEF,
    parameter int unsigned T1H_CYC   = T1H_CYC_DEF,
    parameter int unsigned TBIT_CYC  = TBIT_CYC_DEF,
    parameter int unsigned LATCH_CYC = LATCH_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_last,
`ifdef GRB_BRIGHTNESS_EN
    input  logic [7:0]  bright,
`endif
    output logic        pix_ready,
    output logic        dout,
    output logic        inc_counter,
    output logic        clear_counter,
    output logic        busy,
    output logic        underrun
);

    localparam logic [15:0] T0H_L       = T0H_CYC[15:0];
    localparam logic [15:0] T1H_L       = T1H_CYC[15:0];
    localparam logic [15:0] TBIT_LAST   = TBIT_CYC[15:0] - 16'd1;
    localparam logic [15:0] LATCH_LAST  = LATCH_CYC[15:0] - 16'd1;

    grb_state_t  state_r, state_s;
    logic [15:0] timer_r, timer_s;
    logic [4:0]  idx_r, idx_s;
    logic [23:0] shift_r, shift_s;
    logic        last_r, last_s;
    logic        underrun_r, underrun_s;

    logic        dout_r, dout_s;
    logic        inc_r, inc_s;
    logic        clr_r, clr_s;
    logic        busy_r, busy_s;
    logic        ready_r, ready_s;

    logic [23:0] load_data_s;
    logic        xfer_s;

`ifdef GRB_BRIGHTNESS_EN
    grb_scale u_scale (
        .pix_in  (pix_data),
        .bright  (bright),
        .pix_out (load_data_s)
    );
`else
    assign load_data_s = pix_data;
`endif

    // The ready flop resets high so IDLE is ready right after release;
    // the reset gate keeps the port low while reset is held.
    assign pix_ready     = ready_r & ~reset;
    assign dout          = dout_r;
    assign inc_counter   = inc_r;
    assign clear_counter = clr_r;
    assign busy          = busy_r;
    assign underrun      = underrun_r;
    assign xfer_s        = pix_valid & pix_ready;

    // Next-state, timer and datapath logic of the bit FSM.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        idx_s      = idx_r;
        shift_s    = shift_r;
        last_s     = last_r;
        underrun_s = underrun_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_s = HIGH;
                    timer_s = 16'd0;
                    idx_s   = 5'd23;
                    shift_s = load_data_s;
                    last_s  = pix_last;
                end else begin
                    timer_s = 16'd0;
                end
            end
            HIGH: begin
                // The timer runs across HIGH and LOW so the bit length is
                // fixed at TBIT_CYC regardless of the data value.
                timer_s = timer_r + 16'd1;
                if (timer_r == (high_len(shift_r[23], T0H_L, T1H_L) - 16'd1)) begin
                    state_s = LOW;
                end else begin
                    state_s = HIGH;
                end
            end
            LOW: begin
                if (timer_r == TBIT_LAST) begin
                    timer_s = 16'd0;
                    if (idx_r != 5'd0) begin
                        state_s = HIGH;
                        idx_s   = idx_r - 5'd1;
                        shift_s = {shift_r[22:0], 1'b0};
                    end else if (xfer_s) begin
                        state_s = HIGH;
                        idx_s   = 5'd23;
                        shift_s = load_data_s;
                        last_s  = pix_last;
                    end else begin
                        state_s = LATCH;
                        if (!last_r) begin
                            underrun_s = 1'b1;
                        end else begin
                            underrun_s = underrun_r;
                        end
                    end
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            LATCH: begin
                if (timer_r == LATCH_LAST) begin
                    state_s = IDLE;
                    timer_s = 16'd0;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = 16'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        dout_s  = (state_s == HIGH);
        busy_s  = (state_s != IDLE);
        inc_s   = (state_s == LOW) && (timer_s == TBIT_LAST);
        clr_s   = (state_s == LATCH) && (timer_s == LATCH_LAST);
        ready_s = (state_s == IDLE) ||
                  ((state_s == LOW) && (idx_s == 5'd0) && (timer_s == TBIT_LAST));
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            timer_r    <= 16'd0;
            idx_r      <= 5'd0;
            shift_r    <= 24'd0;
            last_r     <= 1'b0;
            underrun_r <= 1'b0;
            dout_r     <= 1'b0;
            inc_r      <= 1'b0;
            clr_r      <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            idx_r      <= idx_s;
            shift_r    <= shift_s;
            last_r     <= last_s;
            underrun_r <= underrun_s;
            dout_r     <= dout_s;
            inc_r      <= inc_s;
            clr_r      <= clr_s;
            busy_r     <= busy_s;
            ready_r    <= ready_s;
        end
    end

endmodule

// File: tb/tb_grb_bit_encoder.sv
// -----------------------------------------------------------------------------
// tb_grb_bit_encoder
// Directed self-checking bench for grb_bit_encoder with default timing
// (T0H 20, T1H 40, bit 62, latch 2500). A negedge monitor records high-pulse
// lengths, rising-edge cycles and pulse counts; directed tests compare them
// with hand-derived values.
// -----------------------------------------------------------------------------
module tb_grb_bit_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready;
    logic        dout;
    logic        inc_counter;
    logic        clear_counter;
    logic        busy;
    logic        underrun;
`ifdef GRB_BRIGHTNESS_EN
    logic [7:0]  bright;
`endif

    int checks   = 0;
    int failures = 0;

    // monitor state (written only by the monitor process)
    int cyc = 0;
    bit dout_prev = 1'b0;
    int hi_cnt = 0;
    int hi_q[$];
    int rise_q[$];
    int inc_total = 0;
    int clr_total = 0;
    int since_inc = 0;
    int hi_since_inc = 0;
    int latch_len_last = 0;
    int latch_hi_last = 0;
    int last_inc_cyc = 0;
    int last_xfer_cyc = 0;

    always #5 clk = ~clk;

    grb_bit_encoder dut (
        .clk           (clk),
        .reset         (reset),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_last      (pix_last),
`ifdef GRB_BRIGHTNESS_EN
        .bright        (bright),
`endif
        .pix_ready     (pix_ready),
        .dout          (dout),
        .inc_counter   (inc_counter),
        .clear_counter (clear_counter),
        .busy          (busy),
        .underrun      (underrun)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Negedge monitor of the serial line and pulse outputs.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (dout === 1'b1) begin
                if (!dout_prev) rise_q.push_back(cyc);
                hi_cnt++;
            end else begin
                if (dout_prev) hi_q.push_back(hi_cnt);
                hi_cnt = 0;
            end
            dout_prev = (dout === 1'b1);
            if (inc_counter === 1'b1) begin
                inc_total++;
                since_inc = 0;
                hi_since_inc = 0;
                last_inc_cyc = cyc;
            end else begin
                since_inc++;
                if (dout === 1'b1) hi_since_inc++;
            end
            if (clear_counter === 1'b1) begin
                clr_total++;
                latch_len_last = since_inc;
                latch_hi_last = hi_since_inc;
            end
            if (pix_valid === 1'b1 && pix_ready === 1'b1) last_xfer_cyc = cyc;
        end
    end

    task automatic send_pixel(input logic [23:0] d, input logic l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        pix_data  = d;
        pix_last  = l;
        pix_valid = 1'b1;
        while (!ok && n < 5000) begin
            @(negedge clk);
            n++;
            if (pix_ready === 1'b1) ok = 1'b1;
        end
        check_value("send_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) done = 1'b1;
        end
        check_value("idle_reached", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inc(input int target, input int max);
        int n;
        n = 0;
        while (inc_total < target && n < max) begin
            @(negedge clk);
            n++;
        end
        check_value("inc_reached", {31'd0, (inc_total >= target)}, 32'd1);
    endtask

    // Compare a pixel's 24 high pulses starting at hi_q[base] with its data bits.
    task automatic check_pixel_bits(input string tag, input int base, input logic [23:0] px);
        logic [23:0] v;
        v = px;
        for (int i = 0; i < 24; i++) begin
            if (base + i < hi_q.size())
                check_value(tag, hi_q[base + i], v[23 - i] ? 32'd40 : 32'd20);
            else
                check_value(tag, 32'd0, v[23 - i] ? 32'd40 : 32'd20);
        end
    endtask

    initial begin
        int h0, r0, i0, c0, n;
        bit prev_clr, found;
        logic [23:0] t2_px [3];

        t2_px[0] = 24'hA5C3F0;
        t2_px[1] = 24'h0F0F0F;
        t2_px[2] = 24'h123456;

        reset = 1'b1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        pix_data = 24'd0;
`ifdef GRB_BRIGHTNESS_EN
        bright = 8'd255;
`endif
        // reset state
        repeat (3) @(negedge clk);
        check_value("rst_dout", dout, 1'b0);
        check_value("rst_ready", pix_ready, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_inc", inc_counter, 1'b0);
        check_value("rst_clr", clear_counter, 1'b0);
        check_value("rst_underrun", underrun, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("idle_ready", pix_ready, 1'b1);
        check_value("idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // single pixel FF0000, last
        h0 = hi_q.size(); r0 = rise_q.size(); i0 = inc_total; c0 = clr_total;
        send_pixel(24'hFF0000, 1'b1);
        wait_idle(6000);
        check_value("t1_pulses", hi_q.size() - h0, 24);
        check_pixel_bits("t1_high", h0, 24'hFF0000);
        for (int i = 1; i < 24; i++)
            if (r0 + i < rise_q.size())
                check_value("t1_period", rise_q[r0 + i] - rise_q[r0 + i - 1], 62);
        check_value("t1_first_rise", rise_q[r0] - last_xfer_cyc, 1);
        check_value("t1_last_bit", last_inc_cyc - rise_q[r0 + 23] + 1, 62);
        check_value("t1_inc", inc_total - i0, 24);
        check_value("t1_clr", clr_total - c0, 1);
        check_value("t1_latch_len", latch_len_last, 2500);
        check_value("t1_latch_high", latch_hi_last, 0);
        check_value("t1_underrun", underrun, 1'b0);

        // three back-to-back pixels, third last
        h0 = hi_q.size(); r0 = rise_q.size(); i0 = inc_total; c0 = clr_total;
        for (int p = 0; p < 3; p++) send_pixel(t2_px[p], (p == 2));
        wait_idle(10000);
        check_value("t2_pulses", hi_q.size() - h0, 72);
        for (int p = 0; p < 3; p++) check_pixel_bits("t2_high", h0 + 24 * p, t2_px[p]);
        for (int i = 1; i < 72; i++)
            if (r0 + i < rise_q.size())
                check_value("t2_period", rise_q[r0 + i] - rise_q[r0 + i - 1], 62);
        check_value("t2_span", last_inc_cyc - rise_q[r0] + 1, 72 * 62);
        check_value("t2_inc", inc_total - i0, 72);
        check_value("t2_clr", clr_total - c0, 1);
        check_value("t2_underrun", underrun, 1'b0);

        // frame runs dry after a non-last pixel
        h0 = hi_q.size(); i0 = inc_total; c0 = clr_total;
        send_pixel(24'h00FF00, 1'b0);
        wait_idle(6000);
        check_pixel_bits("t3_high", h0, 24'h00FF00);
        check_value("t3_inc", inc_total - i0, 24);
        check_value("t3_clr", clr_total - c0, 1);
        check_value("t3_latch_len", latch_len_last, 2500);
        check_value("t3_underrun", underrun, 1'b1);

        // pixel offered during LATCH is taken on the first IDLE cycle
        h0 = hi_q.size(); i0 = inc_total;
        send_pixel(24'h0000FF, 1'b1);
        wait_inc(i0 + 24, 2000);
        @(posedge clk);
        #1;
        pix_data = 24'hC00001;
        pix_last = 1'b1;
        pix_valid = 1'b1;
        n = 0;
        found = 1'b0;
        prev_clr = 1'b0;
        while (!found && n < 3000) begin
            @(negedge clk);
            n++;
            if (pix_ready === 1'b1) found = 1'b1;
            else prev_clr = clear_counter;
        end
        check_value("t4_accepted", {31'd0, found}, 32'd1);
        check_value("t4_accept_idle", busy, 1'b0);
        check_value("t4_first_idle", {31'd0, prev_clr}, 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        wait_idle(6000);
        check_pixel_bits("t4_high", h0 + 24, 24'hC00001);
        check_value("t4_inc", inc_total - i0, 48);
        check_value("t4_underrun_sticky", underrun, 1'b1);

        // reset in the high phase of bit 10
        i0 = inc_total; c0 = clr_total;
        send_pixel(24'hFFFFFF, 1'b1);
        wait_inc(i0 + 10, 2000);
        repeat (5) @(negedge clk);
        check_value("t5_mid_high", dout, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_value("t5_async_dout", dout, 1'b0);
        check_value("t5_async_busy", busy, 1'b0);
        check_value("t5_async_ready", pix_ready, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_value("t5_idle_busy", busy, 1'b0);
        check_value("t5_idle_ready", pix_ready, 1'b1);
        check_value("t5_idle_dout", dout, 1'b0);
        repeat (200) @(negedge clk);
        check_value("t5_inc", inc_total - i0, 10);
        check_value("t5_clr", clr_total - c0, 0);
        check_value("t5_underrun", underrun, 1'b0);
        @(posedge clk);
        #1;

`ifdef GRB_BRIGHTNESS_EN
        // brightness 127: each channel becomes (c*128)>>8
        bright = 8'd127;
        h0 = hi_q.size();
        send_pixel(24'hFF8040, 1'b1);
        wait_idle(6000);
        check_pixel_bits("t6_bright", h0, 24'h7F4020);
        bright = 8'd255;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
